// File: rtl/io_1_input_sync_filter_if.sv
// Pad-side bundle for io_1_input_sync_filter.
// It carries the raw pad level, the conditioned outputs and the filter threshold.
interface io_1_input_sync_filter_if #(
  parameter int NoConfigBits = 4
);
  logic                    O_top;
  logic                    O;
  logic                    Rise;
  logic                    Fall;
  logic [NoConfigBits-1:0] ConfigBits;

  modport master (
    output O_top,
    output ConfigBits,
    input  O,
    input  Rise,
    input  Fall
  );

  modport slave (
    input  O_top,
    input  ConfigBits,
    output O,
    output Rise,
    output Fall
  );
endinterface

// File: rtl/io_1_input_sync_filter.sv
// Pad input conditioner: synchroniser chain, then a stable-count glitch filter, then optional edge pulses.
// Define IO_SYNC_EDGE_DETECT_EN to build the Rise/Fall pulse logic; otherwise both outputs are tied to 0.
module io_1_input_sync_filter #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 4,
  parameter int NoConfigBits = 4
) (
  input logic                   UserCLK,
  input logic                   RST,
  io_1_input_sync_filter_if.slave io
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = io.O_top;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge UserCLK) begin
    if (RST) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             lvl_reg;

  assign thr     = CNT_W'(io.ConfigBits);
  assign cnt_inc = cnt_reg + CNT_W'(1);

  // The counter only runs while s disagrees with lvl, and it is cleared on
  // acceptance or disagreement ending, so it stays at or below THR-1.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      lvl_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (thr == '0) begin
      lvl_reg <= s;
      cnt_reg <= '0;
    end else if (s == lvl_reg) begin
      cnt_reg <= '0;
    end else if (cnt_inc == thr) begin
      lvl_reg <= s;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_inc;
    end
  end

  assign io.O = lvl_reg;

`ifdef IO_SYNC_EDGE_DETECT_EN
  logic prev_reg;

  // prev clears together with lvl, so neither reset entry nor exit makes a pulse.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= lvl_reg;
    end
  end

  assign io.Rise = lvl_reg & ~prev_reg;
  assign io.Fall = ~lvl_reg & prev_reg;
`else
  assign io.Rise = 1'b0;
  assign io.Fall = 1'b0;
`endif

endmodule

// File: tb/tb_io_1_input_sync_filter.sv
// Scoreboard bench for io_1_input_sync_filter: directed pad vectors push expected O/Rise/Fall,
// and a negedge monitor pops and compares one entry per cycle.
module tb_io_1_input_sync_filter;

`ifdef IO_SYNC_EDGE_DETECT_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic UserCLK = 1'b0;
  logic RST     = 1'b1;

  always #5 UserCLK = ~UserCLK;

  io_1_input_sync_filter_if #(.NoConfigBits(4)) io ();

  io_1_input_sync_filter #(
    .SYNC_STAGES (2),
    .CNT_W       (4),
    .NoConfigBits(4)
  ) dut (
    .UserCLK(UserCLK),
    .RST    (RST),
    .io     (io)
  );

  typedef struct {
    logic [2:0] exp;
    string      tag;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: the DUT presents a fresh O/Rise/Fall every cycle.
  initial begin
    forever begin
      @(negedge UserCLK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({io.O, io.Rise, io.Fall} !== mon_e.exp) begin
          errors++;
          $display("FAIL %s step %0d: O/Rise/Fall got %b required %b",
                   mon_e.tag, mon_e.idx, {io.O, io.Rise, io.Fall}, mon_e.exp);
        end else begin
          $display("check %s step %0d: O/Rise/Fall %b", mon_e.tag, mon_e.idx, mon_e.exp);
        end
      end
    end
  end

  function automatic logic bit_of(input string s, input int i);
    return (s[i] == 8'h31);
  endfunction

  // Drive one cycle of stimulus and queue the output expected right after the next edge.
  task automatic step(input logic rst, input logic pad, input logic [3:0] thr,
                      input logic [2:0] exp, input string tag, input int idx);
    exp_t e;
    @(negedge UserCLK);
    #1;
    RST           = rst;
    io.O_top      = pad;
    io.ConfigBits = thr;
    e.exp = exp;
    e.tag = tag;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Three reset cycles (threshold loaded under reset), then the vector.
  task automatic run_vec(input string tag, input logic [3:0] thr, input logic rst_pad,
                         input string pad, input string o, input string r, input string f);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rst_pad, thr, 3'b000, {tag, "_rst"}, i);
    end
    for (int i = 0; i < pad.len(); i++) begin
      logic [2:0] e;
      e = {bit_of(o, i), EDGE_EN & bit_of(r, i), EDGE_EN & bit_of(f, i)};
      step(1'b0, bit_of(pad, i), thr, e, tag, i + 1);
    end
  endtask

  string p5, o5, r5, f5;

  initial begin
    io.O_top      = 1'b0;
    io.ConfigBits = 4'd0;

    // THR=0: rise seen two edges after the pad, fall likewise.
    run_vec("thr0", 4'd0, 1'b0,
            "00111110000",
            "00001111100",
            "00001000000",
            "00000000010");

    // THR=1 must be cycle-identical to THR=0.
    run_vec("thr1", 4'd1, 1'b0,
            "00111110000",
            "00001111100",
            "00001000000",
            "00000000010");

    // THR=5: a 4-cycle glitch is rejected, then a 5-cycle pulse passes.
    run_vec("thr5", 4'd5, 1'b0,
            "01111000000001111100000000",
            "00000000000000000001111100",
            "00000000000000000001000000",
            "00000000000000000000000010");

    // THR=15: 8-cycle toggles never qualify; a steady high lands 16 edges after sync.
    p5 = ""; o5 = ""; r5 = ""; f5 = "";
    for (int i = 0; i < 52; i++) begin
      if (i < 32) p5 = {p5, (((i / 8) % 2) == 0) ? "1" : "0"};
      else        p5 = {p5, "1"};
      o5 = {o5, (i + 1 >= 49) ? "1" : "0"};
      r5 = {r5, (i + 1 == 49) ? "1" : "0"};
      f5 = {f5, "0"};
    end
    run_vec("thr15", 4'd15, 1'b0, p5, o5, r5, f5);

    // Reset entered while O=1 with the pad held high: no Fall, then full latency at THR=2.
    run_vec("rst", 4'd2, 1'b1,
            "111111",
            "000111",
            "000100",
            "000000");

    @(negedge UserCLK);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
